// File: rtl/dram_seq_pkg.sv
// Shared types and defaults for the DRAM sequencer slice.
//   state_t   : sequencer FSM states
//   *_DEF     : default parameter values used by the modules and the interface
//   ADDR_BITS : request address width for the default row width
package dram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAS  = 3'd1,
    MUX  = 3'd2,
    CAS  = 3'd3,
    REF  = 3'd4,
    PRE  = 3'd5
  } state_t;

  localparam int unsigned ROW_BITS_DEF         = 8;
  localparam int unsigned REFRESH_INTERVAL_DEF = 120;
  localparam int unsigned CAS_CYCLES_DEF       = 2;
  localparam int unsigned RAS_PRE_DEF          = 2;

  localparam int unsigned ADDR_BITS = 2 * ROW_BITS_DEF;

  // Address bus width for an arbitrary row width.
  function automatic int unsigned addr_bits(input int unsigned row_bits);
    return 2 * row_bits;
  endfunction

endpackage

// File: rtl/dram_sequencer_if.sv
// Requester-side bus and DRAM-side strobes of one sequenced DRAM bank.
//   master : requester view (drives req/we/addr, observes everything else)
//   slave  : sequencer view (samples req/we/addr, drives ack/busy/strobes/ma)
interface dram_sequencer_if
  import dram_seq_pkg::*;
#(
  parameter int unsigned ROW_BITS = ROW_BITS_DEF
);

  logic                    req;
  logic                    we;
  logic [2*ROW_BITS-1:0]   addr;
  logic                    ack;
  logic                    busy;
  logic                    ras_n;
  logic                    cas_n;
  logic                    we_n;
  logic                    mux_sel;
  logic [ROW_BITS-1:0]     ma;

  modport master (
    output req, we, addr,
    input  ack, busy, ras_n, cas_n, we_n, mux_sel, ma
  );

  modport slave (
    input  req, we, addr,
    output ack, busy, ras_n, cas_n, we_n, mux_sel, ma
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with a single pending-request flag.
//   clk         : clock, rising edge
//   clr         : synchronous active-high reset
//   ack_refresh : sequencer is starting the pending refresh this cycle
//   ref_pending : a refresh is owed (registered)
module dram_refresh_timer
  import dram_seq_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic ack_refresh,
  output logic ref_pending
);

  localparam int unsigned TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TC = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          tc;

  always_comb begin
    tc        = (timer_q == TC);
    timer_d   = tc ? '0 : timer_q + 1'b1;
    // A terminal count wins over an acknowledge on the same edge; a terminal
    // count while already pending simply merges into the one flag.
    pending_d = (pending_q & ~ack_refresh) | tc;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign ref_pending = pending_q;

endmodule

// File: rtl/dram_sequencer.sv
// Sequencer for one multiplexed-address DRAM bank with RAS-only refresh.
//   clk : clock, rising edge
//   clr : synchronous active-high reset; aborts any cycle in progress
//   bus : slave side of dram_sequencer_if
//         req/we/addr in (addr = {row, column}), ack one-cycle pulse in the
//         last CAS cycle, busy while not IDLE, ras_n/cas_n/we_n strobes,
//         mux_sel (0 = row/refresh, 1 = column), ma multiplexed address.
// Every output is a register; refresh takes priority over new requests.
module dram_sequencer
  import dram_seq_pkg::*;
#(
  parameter int unsigned ROW_BITS         = ROW_BITS_DEF,
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int unsigned CAS_CYCLES       = CAS_CYCLES_DEF,
  parameter int unsigned RAS_PRE          = RAS_PRE_DEF
) (
  input  logic                clk,
  input  logic                clr,
  dram_sequencer_if.slave     bus
);

  localparam int unsigned AW      = 2 * ROW_BITS;
  localparam int unsigned CNT_MAX = (CAS_CYCLES > RAS_PRE) ? CAS_CYCLES : RAS_PRE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(CAS_CYCLES);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(RAS_PRE - 1);
  localparam logic             CAS_ONE  = (CAS_CYCLES == 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ROW_BITS-1:0] ref_row_q;
  logic [ROW_BITS-1:0] col_q;
  logic                wr_q;

  logic                ras_n_q, cas_n_q, we_n_q, mux_sel_q, ack_q, busy_q;
  logic [ROW_BITS-1:0] ma_q;

  logic ref_pending;
  logic ack_refresh;

  assign cnt_inc     = cnt_q + 1'b1;
  assign ack_refresh = (state_q == IDLE) && ref_pending;

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk         (clk),
    .clr         (clr),
    .ack_refresh (ack_refresh),
    .ref_pending (ref_pending)
  );

  // Outputs are registered alongside the state: each branch loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_row_q <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      ras_n_q   <= 1'b1;
      cas_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      mux_sel_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      ma_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ref_pending) begin
            state_q   <= REF;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            ras_n_q   <= 1'b0;
            mux_sel_q <= 1'b0;
            ma_q      <= ref_row_q;
          end else if (bus.req) begin
            state_q   <= RAS;
            busy_q    <= 1'b1;
            ras_n_q   <= 1'b0;
            mux_sel_q <= 1'b0;
            ma_q      <= bus.addr[AW-1:ROW_BITS];
            col_q     <= bus.addr[ROW_BITS-1:0];
            wr_q      <= bus.we;
          end
        end
        RAS: begin
          state_q   <= MUX;
          mux_sel_q <= 1'b1;
          ma_q      <= col_q;
        end
        MUX: begin
          state_q <= CAS;
          cnt_q   <= '0;
          cas_n_q <= 1'b0;
          we_n_q  <= ~wr_q;
          ack_q   <= CAS_ONE;
        end
        CAS: begin
          if (cnt_q == CAS_LAST) begin
            state_q   <= PRE;
            cnt_q     <= '0;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            mux_sel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
            ack_q <= (cnt_inc == CAS_LAST);
          end
        end
        REF: begin
          if (cnt_q == REF_LAST) begin
            state_q   <= PRE;
            cnt_q     <= '0;
            ras_n_q   <= 1'b1;
            ref_row_q <= ref_row_q + 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRE: begin
          if (cnt_q == PRE_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ras_n   = ras_n_q;
  assign bus.cas_n   = cas_n_q;
  assign bus.we_n    = we_n_q;
  assign bus.mux_sel = mux_sel_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.ma      = ma_q;

endmodule
